// File: rtl/fifo_drain_scheduler_if.sv
// Handshake bundle between the FIFO drain scheduler and its environment.
// slave: scheduler side; master: FIFO/engine side (drives flags, data, ready).
interface fifo_drain_scheduler_if #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
);
  logic                  enable;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic [DATA_WIDTH-1:0] fifo_output;
  logic                  read_enable;
  logic [DATA_WIDTH-1:0] sample_data;
  logic                  sample_valid;
  logic                  sample_ready;
  logic                  window_last;
  logic [CNT_WIDTH-1:0]  window_count;
  logic                  busy;
  logic [CNT_WIDTH-1:0]  overflow_count;

  modport slave (
    input  enable, fifo_empty, fifo_full, fifo_output, sample_ready,
    output read_enable, sample_data, sample_valid, window_last,
    output window_count, busy, overflow_count
  );

  modport master (
    output enable, fifo_empty, fifo_full, fifo_output, sample_ready,
    input  read_enable, sample_data, sample_valid, window_last,
    input  window_count, busy, overflow_count
  );
endinterface

// File: rtl/fifo_drain_scheduler.sv
// Drains a FIFO one word per 3 cycles into a valid/ready scoring stream, tagging
// window boundaries. Ports: clk, reset (sync, active-low), bus (slave modport).
// Optional macro FIFO_OVERFLOW_CNT_EN: saturating count of fifo_full cycles.
module fifo_drain_scheduler #(
  parameter int DATA_WIDTH = 8,
  parameter int WINDOW_LEN = 16,
  parameter int CNT_WIDTH  = 16
) (
  input logic                   clk,
  input logic                   reset,
  fifo_drain_scheduler_if.slave bus
);

  localparam int IW = (WINDOW_LEN > 1) ? $clog2(WINDOW_LEN) : 1;
  localparam logic [IW-1:0] LAST = IW'(WINDOW_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_CAPT,
    S_OUT
  } state_t;

  state_t                state_q, state_d;
  logic                  armed_q;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [CNT_WIDTH-1:0]  wcnt_q, wcnt_d;
  logic                  go;
  logic                  hs;
  logic                  last;

  // armed_q blocks a read on the first edge after reset release
  assign go   = armed_q && bus.enable && !bus.fifo_empty;
  assign hs   = (state_q == S_OUT) && bus.sample_ready;
  assign last = (idx_q == LAST);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      armed_q <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (go) state_d = S_READ;
      S_READ: state_d = S_CAPT;
      S_CAPT: state_d = S_OUT;
      S_OUT: begin
        if (hs) state_d = go ? S_READ : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.read_enable  = (state_q == S_READ);
    bus.sample_valid = (state_q == S_OUT);
    bus.busy         = (state_q != S_IDLE);
    bus.sample_data  = data_q;
    bus.window_last  = last;
    bus.window_count = wcnt_q;
  end

  always_comb begin
    data_d = data_q;
    idx_d  = idx_q;
    wcnt_d = wcnt_q;
    if (state_q == S_CAPT) data_d = bus.fifo_output;
    if (hs) begin
      if (last) begin
        idx_d  = '0;
        wcnt_d = wcnt_q + 1'b1;
      end else begin
        idx_d  = idx_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      data_q <= '0;
      idx_q  <= '0;
      wcnt_q <= '0;
    end else begin
      data_q <= data_d;
      idx_q  <= idx_d;
      wcnt_q <= wcnt_d;
    end
  end

`ifdef FIFO_OVERFLOW_CNT_EN
  logic [CNT_WIDTH-1:0] ovf_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      ovf_q <= '0;
    end else if (bus.fifo_full && (ovf_q != '1)) begin
      ovf_q <= ovf_q + 1'b1;
    end
  end

  assign bus.overflow_count = ovf_q;
`else
  logic unused_full;

  assign unused_full        = bus.fifo_full;
  assign bus.overflow_count = '0;
`endif

endmodule

// File: tb/tb_fifo_drain_scheduler.sv
// Self-checking bench for fifo_drain_scheduler: FIFO model plus data scoreboard,
// with directed latency, stall, window, enable-drop, overflow and reset cases.
module tb_fifo_drain_scheduler;

  logic clk;
  logic reset;

  logic [7:0]  fq[$];
  logic [7:0]  sb[$];
  int          m_idx;
  logic [15:0] m_wc;
  int          n_cmp;
  int          n_err;
  logic [15:0] exp_ovf;

  fifo_drain_scheduler_if #(.DATA_WIDTH(8), .CNT_WIDTH(16)) bus ();

  fifo_drain_scheduler #(
    .DATA_WIDTH(8),
    .WINDOW_LEN(16),
    .CNT_WIDTH (16)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string tag, input int max, input bit rnd);
    bit done;
    done = 1'b0;
    for (int i = 0; i < max && !done; i++) begin
      if (rnd) bus.sample_ready = 1'($urandom_range(0, 1));
      tick();
      done = !bus.busy && (fq.size() == 0);
    end
    chk(tag, 32'(done), 1);
  endtask

  task automatic wait_re(input string tag, input int max);
    bit done;
    done = 1'b0;
    for (int i = 0; i < max && !done; i++) begin
      tick();
      done = bus.read_enable;
    end
    chk(tag, 32'(done), 1);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_re"}, 32'(bus.read_enable), 0);
    chk({tag, "_sv"}, 32'(bus.sample_valid), 0);
    chk({tag, "_data"}, 32'(bus.sample_data), 0);
    chk({tag, "_last"}, 32'(bus.window_last), 0);
    chk({tag, "_busy"}, 32'(bus.busy), 0);
    chk({tag, "_wcnt"}, 32'(bus.window_count), 0);
    chk({tag, "_ovf"}, 32'(bus.overflow_count), 0);
  endtask

  // FIFO model and scoreboard, sampled mid-cycle
  initial begin
    logic [7:0] d;
    logic [7:0] e;
    bus.fifo_empty  = 1'b1;
    bus.fifo_output = '0;
    forever begin
      @(negedge clk);
      if (bus.read_enable) begin
        chk("rd_nonempty", 32'(fq.size() != 0), 1);
        if (fq.size() != 0) begin
          d = fq.pop_front();
          bus.fifo_output = d;
          sb.push_back(d);
        end
      end
      if (!reset) begin
        sb.delete();
        m_idx = 0;
        m_wc  = '0;
      end else if (bus.sample_valid && bus.sample_ready) begin
        chk("hs_have_exp", 32'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("hs_data", 32'(bus.sample_data), 32'(e));
        end
        chk("hs_last", 32'(bus.window_last), 32'(m_idx == 15));
        chk("hs_wcnt", 32'(bus.window_count), 32'(m_wc));
        if (m_idx == 15) begin
          m_idx = 0;
          m_wc  = m_wc + 16'd1;
        end else begin
          m_idx = m_idx + 1;
        end
      end
      bus.fifo_empty = (fq.size() == 0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    m_idx = 0;
    m_wc  = '0;
`ifdef FIFO_OVERFLOW_CNT_EN
    exp_ovf = 16'd5;
`else
    exp_ovf = 16'd0;
`endif
    reset            = 1'b0;
    bus.enable       = 1'b0;
    bus.fifo_full    = 1'b0;
    bus.sample_ready = 1'b0;
    repeat (3) tick();
    chk_reset("rst");
    reset = 1'b1;
    tick();
    chk("rel_re", 32'(bus.read_enable), 0);

    // first-sample latency
    fq.push_back(8'h5A);
    bus.enable       = 1'b1;
    bus.sample_ready = 1'b1;
    tick();
    chk("lat_re1", 32'(bus.read_enable), 1);
    tick();
    chk("lat_re2", 32'(bus.read_enable), 0);
    chk("lat_sv2", 32'(bus.sample_valid), 0);
    tick();
    chk("lat_sv3", 32'(bus.sample_valid), 1);
    chk("lat_data", 32'(bus.sample_data), 32'h5A);
    tick();
    chk("lat_idle", 32'(bus.busy), 0);
    tick();
    chk("empty_re", 32'(bus.read_enable), 0);
    chk("empty_busy", 32'(bus.busy), 0);

    // downstream stall
    bus.sample_ready = 1'b0;
    fq.push_back(8'h11);
    fq.push_back(8'h22);
    begin
      bit got;
      got = 1'b0;
      for (int i = 0; i < 10 && !got; i++) begin
        tick();
        got = bus.sample_valid;
      end
      chk("stall_sv_seen", 32'(got), 1);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("stall_sv", 32'(bus.sample_valid), 1);
      chk("stall_data", 32'(bus.sample_data), 32'h11);
      chk("stall_re", 32'(bus.read_enable), 0);
      chk("stall_last", 32'(bus.window_last), 0);
    end
    bus.sample_ready = 1'b1;
    wait_idle("stall_drain", 30, 1'b0);

    // full windows with random backpressure
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    for (int i = 0; i < 16; i++) fq.push_back(8'($urandom_range(0, 255)));
    wait_idle("win1_drain", 200, 1'b1);
    chk("win1_wcnt", 32'(bus.window_count), 1);
    chk("win1_last", 32'(bus.window_last), 0);
    for (int i = 0; i < 20; i++) fq.push_back(8'($urandom_range(0, 255)));
    wait_idle("win2_drain", 250, 1'b1);
    chk("win2_wcnt", 32'(bus.window_count), 2);

    // enable dropped during CAPTURE
    bus.sample_ready = 1'b1;
    fq.push_back(8'hA1);
    fq.push_back(8'hB2);
    wait_re("drop_re", 5);
    tick();
    bus.enable = 1'b0;
    tick();
    chk("drop_sv", 32'(bus.sample_valid), 1);
    tick();
    chk("drop_idle", 32'(bus.busy), 0);
    repeat (3) tick();
    chk("drop_stay_busy", 32'(bus.busy), 0);
    chk("drop_stay_re", 32'(bus.read_enable), 0);
    bus.enable = 1'b1;
    wait_idle("drop_drain", 30, 1'b0);

    // overflow counter
    bus.fifo_full = 1'b1;
    repeat (5) tick();
    bus.fifo_full = 1'b0;
    chk("ovf_5", 32'(bus.overflow_count), 32'(exp_ovf));
    tick();
    chk("ovf_hold", 32'(bus.overflow_count), 32'(exp_ovf));

    // reset during READ
    fq.push_back(8'hC3);
    fq.push_back(8'hD4);
    fq.push_back(8'hE5);
    wait_re("rstrd_re", 5);
    reset = 1'b0;
    tick();
    chk_reset("rstrd");
    reset = 1'b1;
    tick();
    chk("rstrd_rel_re", 32'(bus.read_enable), 0);
    tick();
    chk("rstrd_resume", 32'(bus.read_enable), 1);
    wait_idle("rstrd_drain", 30, 1'b0);

    chk("end_sb", 32'(sb.size()), 0);
    chk("end_wcnt", 32'(bus.window_count), 32'(m_wc));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
